// File: rtl/halt_ctrl.sv
// -----------------------------------------------------------------------------
// halt_ctrl
// Run-control block beside the CPU writeback stage. It tracks the return-value
// register as instructions retire, freezes fetch when a halt retires, drains
// the memory side for DRAIN_CYCLES cycles, then holds is_halt with the captured
// return value. A watchdog forces a timeout stop if no halt retires within
// WDOG_CYCLES RUN cycles.
//
// Parameters:
//   DATA_W       register / return-value width
//   RET_REG      register index reported as return value (1..7)
//   DRAIN_CYCLES cycles spent draining before is_halt (1..255)
//   WDOG_CYCLES  RUN-state cycle budget before timeout (>= 2)
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   wb_valid     instruction retires this cycle
//   wb_is_halt   retiring instruction is halt (qualified by wb_valid)
//   wb_we        retiring instruction writes a register (qualified by wb_valid)
//   wb_rd        destination register index
//   wb_data      writeback data
//   stall_req    freeze fetch/issue (registered)
//   is_halt      program halted, held until reset
//   ret_val      captured return value (shadow register)
//   timeout      watchdog expired, held until reset
//   cycles       RUN-state cycle count, frozen on leaving RUN
//
// Optional build macro: HALT_CTRL_TRACE_EN
//   Defined: prints a message on entry to HALTED / TIMEOUT (simulation only).
//   Undefined: fully synthesizable; port behaviour identical.
// -----------------------------------------------------------------------------
module halt_ctrl #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RET_REG      = 3,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned WDOG_CYCLES  = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic              wb_is_halt,
    input  logic              wb_we,
    input  logic [2:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_req,
    output logic              is_halt,
    output logic [DATA_W-1:0] ret_val,
    output logic              timeout,
    output logic [31:0]       cycles
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CYC_W  = 32;

    localparam logic [2:0]       RET_IDX    = 3'(RET_REG);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CYC_W-1:0] WDOG_LAST  = CYC_W'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [DATA_W-1:0]  r_shadow;
    logic [CYC_W-1:0]   r_cycles;
    logic               r_stall;
    logic               r_is_halt;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_drain_cnt_nxt;
    logic [DATA_W-1:0]  w_shadow_nxt;
    logic [CYC_W-1:0]   w_cycles_nxt;
    logic               w_stall_nxt;
    logic               w_is_halt_nxt;
    logic               w_timeout_nxt;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            r_shadow    <= '0;
            r_cycles    <= '0;
            r_stall     <= 1'b0;
            r_is_halt   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_cycles    <= w_cycles_nxt;
            r_stall     <= w_stall_nxt;
            r_is_halt   <= w_is_halt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state, shadow capture, drain and cycle counting.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_shadow_nxt    = r_shadow;
        w_cycles_nxt    = r_cycles;

        case (r_state)
            S_RUN: begin
                if (r_cycles != '1) begin
                    w_cycles_nxt = r_cycles + CYC_W'(1);
                end
                // A RET_REG write retiring alongside the halt is still captured.
                if (wb_valid && wb_we && (wb_rd == RET_IDX)) begin
                    w_shadow_nxt = wb_data;
                end
                // Halt takes priority over a same-cycle watchdog expiry.
                if (wb_valid && wb_is_halt) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = DRAIN_LOAD;
                end else if (r_cycles == WDOG_LAST) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        w_stall_nxt   = (w_state_nxt != S_RUN);
        w_is_halt_nxt = (w_state_nxt == S_HALTED);
        w_timeout_nxt = (w_state_nxt == S_TIMEOUT);
    end

    assign stall_req = r_stall;
    assign is_halt   = r_is_halt;
    assign timeout   = r_timeout;
    assign ret_val   = r_shadow;
    assign cycles    = r_cycles;

`ifdef HALT_CTRL_TRACE_EN
    // One-shot messages on entry to the terminal states.
    always @(posedge clk) begin
        if (rst_n && (r_state == S_DRAIN) && (w_state_nxt == S_HALTED)) begin
            $display("Finished with << %0d >>", r_shadow);
        end
        if (rst_n && (r_state == S_RUN) && (w_state_nxt == S_TIMEOUT)) begin
            $display("ran for %0d cycles", w_cycles_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_halt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_halt_ctrl
// Self-checking bench for halt_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model
// that tracks time since reset release and the time RUN was left.
// -----------------------------------------------------------------------------
module tb_halt_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned RR = 3;
    localparam int unsigned DC = 4;
    localparam int unsigned WD = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_is_halt = 1'b0;
    logic          wb_we = 1'b0;
    logic [2:0]    wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          stall_req;
    logic          is_halt;
    logic [DW-1:0] ret_val;
    logic          timeout;
    logic [31:0]   cycles;

    int total = 0;
    int bad   = 0;

    halt_ctrl #(
        .DATA_W(DW), .RET_REG(RR), .DRAIN_CYCLES(DC), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_is_halt(wb_is_halt), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_req(stall_req), .is_halt(is_halt), .ret_val(ret_val),
        .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Reference model: t = edges since reset release, stop_t = edge at which
    // RUN was left (0 while still running), stop_halt = left because of halt.
    int            m_t = 0;
    int            m_stop_t = 0;
    bit            m_stop_halt = 1'b0;
    logic [DW-1:0] m_shadow = '0;

    task automatic model_step(input logic r, input logic v, input logic h,
                              input logic w, input logic [2:0] rd,
                              input logic [DW-1:0] d);
        if (!r) begin
            m_t = 0; m_stop_t = 0; m_stop_halt = 1'b0; m_shadow = '0;
        end else begin
            m_t = m_t + 1;
            if (m_stop_t == 0) begin
                if (v && w && (int'(rd) == RR)) m_shadow = d;
                if (v && h) begin
                    m_stop_t = m_t; m_stop_halt = 1'b1;
                end else if (m_t == WD) begin
                    m_stop_t = m_t; m_stop_halt = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic        e_stall, e_halt, e_to;
        logic [31:0] e_cyc;
        e_stall = (m_stop_t != 0);
        e_halt  = (m_stop_t != 0) && m_stop_halt && (m_t >= m_stop_t + int'(DC));
        e_to    = (m_stop_t != 0) && !m_stop_halt;
        e_cyc   = (m_stop_t != 0) ? 32'(m_stop_t) : 32'(m_t);
        chk({tag, ".stall_req"}, 32'(stall_req), 32'(e_stall));
        chk({tag, ".is_halt"},   32'(is_halt),   32'(e_halt));
        chk({tag, ".timeout"},   32'(timeout),   32'(e_to));
        chk({tag, ".ret_val"},   32'(ret_val),   32'(m_shadow));
        chk({tag, ".cycles"},    cycles,         e_cyc);
        chk({tag, ".exclusive"}, 32'(is_halt & timeout), 32'd0);
    endtask

    // Apply one cycle of inputs, update the model at the edge, sample after it.
    task automatic step(input logic r, input logic v, input logic h, input logic w,
                        input logic [2:0] rd, input logic [DW-1:0] d);
        @(negedge clk);
        rst_n = r; wb_valid = v; wb_is_halt = h; wb_we = w; wb_rd = rd; wb_data = d;
        @(posedge clk);
        model_step(r, v, h, w, rd, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, '0);
    endtask

    typedef struct {
        logic          r, v, h, w;
        logic [2:0]    rd;
        logic [DW-1:0] d;
        logic          e_stall, e_halt, e_to;
        logic [DW-1:0] e_ret;
        logic [31:0]   e_cyc;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic h, logic w, logic [2:0] rd,
                                logic [DW-1:0] d, logic es, logic eh, logic et,
                                logic [DW-1:0] er, logic [31:0] ec);
        vec_t x;
        x.r = r; x.v = v; x.h = h; x.w = w; x.rd = rd; x.d = d;
        x.e_stall = es; x.e_halt = eh; x.e_to = et; x.e_ret = er; x.e_cyc = ec;
        return x;
    endfunction

    vec_t tbl[14];

    initial begin
        // Write 42 to r3 at cycle 2, other-register writes, halt at cycle 7,
        // then 0xFFFF writes to r3 during DRAIN and HALTED.
        tbl[0]  = mk(0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0, 16'd0,  0);
        tbl[1]  = mk(1, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0, 16'd0,  1);
        tbl[2]  = mk(1, 1, 0, 1, 3'd3, 16'h002A, 0, 0, 0, 16'd42, 2);
        tbl[3]  = mk(1, 0, 0, 1, 3'd3, 16'h0BAD, 0, 0, 0, 16'd42, 3);
        tbl[4]  = mk(1, 1, 0, 1, 3'd2, 16'h0055, 0, 0, 0, 16'd42, 4);
        tbl[5]  = mk(1, 1, 0, 1, 3'd0, 16'h0066, 0, 0, 0, 16'd42, 5);
        tbl[6]  = mk(1, 1, 0, 0, 3'd3, 16'h0077, 0, 0, 0, 16'd42, 6);
        tbl[7]  = mk(1, 1, 1, 0, 3'd0, 16'h0000, 1, 0, 0, 16'd42, 7);
        tbl[8]  = mk(1, 1, 0, 1, 3'd3, 16'hFFFF, 1, 0, 0, 16'd42, 7);
        tbl[9]  = mk(1, 1, 1, 1, 3'd3, 16'hFFFF, 1, 0, 0, 16'd42, 7);
        tbl[10] = mk(1, 0, 0, 0, 3'd0, 16'h0000, 1, 0, 0, 16'd42, 7);
        tbl[11] = mk(1, 1, 0, 1, 3'd3, 16'hFFFF, 1, 1, 0, 16'd42, 7);
        tbl[12] = mk(1, 1, 1, 1, 3'd3, 16'hFFFF, 1, 1, 0, 16'd42, 7);
        tbl[13] = mk(1, 0, 0, 0, 3'd0, 16'h0000, 1, 1, 0, 16'd42, 7);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].w, tbl[i].rd, tbl[i].d);
            chk($sformatf("tbl%0d.stall_req", i), 32'(stall_req), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d.is_halt", i),   32'(is_halt),   32'(tbl[i].e_halt));
            chk($sformatf("tbl%0d.timeout", i),   32'(timeout),   32'(tbl[i].e_to));
            chk($sformatf("tbl%0d.ret_val", i),   32'(ret_val),   32'(tbl[i].e_ret));
            chk($sformatf("tbl%0d.cycles", i),    cycles,         tbl[i].e_cyc);
        end

        // Same-cycle RET_REG write and halt.
        step(0, 0, 0, 0, 3'd0, '0);
        step(1, 1, 1, 1, 3'd3, 16'h1234);
        chk("same.ret_val", 32'(ret_val), 32'h1234);
        chk("same.stall_req", 32'(stall_req), 32'd1);
        idle(3);
        chk("same.is_halt_early", 32'(is_halt), 32'd0);
        idle(1);
        chk("same.is_halt", 32'(is_halt), 32'd1);
        chk("same.ret_hold", 32'(ret_val), 32'h1234);
        check_model("same");

        // Writes to r2 and r0 only.
        step(0, 0, 0, 0, 3'd0, '0);
        step(1, 1, 0, 1, 3'd2, 16'hBEEF);
        step(1, 1, 0, 1, 3'd0, 16'hCAFE);
        step(1, 1, 1, 0, 3'd0, '0);
        idle(DC);
        chk("other.is_halt", 32'(is_halt), 32'd1);
        chk("other.ret_val", 32'(ret_val), 32'd0);
        chk("other.cycles", cycles, 32'd3);

        // Watchdog expiry with no halt.
        step(0, 0, 0, 0, 3'd0, '0);
        idle(WD - 1);
        chk("wdog.pre_timeout", 32'(timeout), 32'd0);
        chk("wdog.pre_stall", 32'(stall_req), 32'd0);
        idle(1);
        chk("wdog.timeout", 32'(timeout), 32'd1);
        chk("wdog.stall_req", 32'(stall_req), 32'd1);
        chk("wdog.is_halt", 32'(is_halt), 32'd0);
        chk("wdog.cycles", cycles, 32'(WD));
        step(1, 1, 1, 1, 3'd3, 16'h5555);
        idle(DC + 1);
        chk("wdog.hold_timeout", 32'(timeout), 32'd1);
        chk("wdog.hold_is_halt", 32'(is_halt), 32'd0);
        chk("wdog.hold_cycles", cycles, 32'(WD));
        chk("wdog.hold_ret", 32'(ret_val), 32'd0);

        // Halt retiring on the watchdog expiry cycle wins.
        step(0, 0, 0, 0, 3'd0, '0);
        idle(WD - 1);
        step(1, 1, 1, 0, 3'd0, '0);
        chk("tie.stall_req", 32'(stall_req), 32'd1);
        chk("tie.timeout", 32'(timeout), 32'd0);
        chk("tie.cycles", cycles, 32'(WD));
        idle(DC);
        chk("tie.is_halt", 32'(is_halt), 32'd1);
        chk("tie.timeout_low", 32'(timeout), 32'd0);

        // Reset during the second DRAIN cycle, then a normal halt.
        step(0, 0, 0, 0, 3'd0, '0);
        step(1, 1, 0, 1, 3'd3, 16'h00AA);
        step(1, 1, 1, 0, 3'd0, '0);
        idle(1);
        step(0, 0, 0, 0, 3'd0, '0);
        chk("mid.stall_req", 32'(stall_req), 32'd0);
        chk("mid.is_halt", 32'(is_halt), 32'd0);
        chk("mid.ret_val", 32'(ret_val), 32'd0);
        chk("mid.cycles", cycles, 32'd0);
        step(1, 1, 0, 1, 3'd3, 16'h0077);
        step(1, 1, 1, 0, 3'd0, '0);
        idle(DC - 1);
        chk("mid.is_halt_early", 32'(is_halt), 32'd0);
        idle(1);
        chk("mid.is_halt_after", 32'(is_halt), 32'd1);
        chk("mid.ret_after", 32'(ret_val), 32'h0077);
        chk("mid.cycles_after", cycles, 32'd2);

        // Randomized stimulus against the model.
        step(0, 0, 0, 0, 3'd0, '0);
        for (int i = 0; i < 3000; i++) begin
            logic r, v, h, w;
            logic [2:0] rd;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 39) != 0);
            v  = ($urandom_range(0, 1) == 1);
            h  = ($urandom_range(0, 7) == 0);
            w  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
            d  = DW'($urandom);
            step(r, v, h, w, rd, d);
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
